// File: rtl/rice_residual_assembler.sv
// ============================================================================
// Module   : rice_residual_assembler
// Purpose  : Rebuilds Rice-coded values into signed residuals, tracks partitions
//            and buffers results for the LPC restore stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rice_residual_assembler #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  input  logic [15:0]       iBlockSize,
  input  logic [3:0]        iPartOrder,
  input  logic [5:0]        iPredOrder,
  input  logic [3:0]        iRiceParam,
  input  logic              iParamValid,
  output logic              oDecEn,
  input  logic              iDecDone,
  input  logic [DATA_W-1:0] iMSB,
  input  logic [DATA_W-1:0] iLSB,
  output logic [DATA_W-1:0] oResidual,
  output logic              oValid,
  input  logic              iReady,
  output logic [15:0]       oPartIdx,
  output logic              oPartDone,
  output logic              oBlockDone,
  output logic              oBusy,
  output logic              oOverflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] C_FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] C_EN_LIMIT = (AW+1)'(FIFO_DEPTH - 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PARAM = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [15:0]       part_len_q, part_len_d;
  logic [3:0]        pord_q, pord_d;
  logic [5:0]        pred_q, pred_d;
  logic [15:0]       part_idx_q, part_idx_d;
  logic [3:0]        k_q, k_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       fcnt_q;
  logic              ovf_q;

  logic [15:0]       w_last_idx;
  logic              w_is_last;
  logic [15:0]       w_first_len;
  logic [15:0]       w_load_cnt;
  logic [DATA_W-1:0] w_mask, w_u, w_res;
  logic              w_push_req, w_push, w_pop, w_full;

  assign w_last_idx  = (16'd1 << pord_q) - 16'd1;
  assign w_is_last   = (part_idx_q == w_last_idx);
  // Partition 0 carries the warm-up samples, which are not Rice coded.
  assign w_first_len = (part_len_q > {10'd0, pred_q}) ? (part_len_q - {10'd0, pred_q}) : 16'd0;
  assign w_load_cnt  = (part_idx_q == 16'd0) ? w_first_len : part_len_q;

  assign w_mask = (DATA_W'(1) << k_q) - DATA_W'(1);
  assign w_u    = (iMSB << k_q) | (iLSB & w_mask);
  assign w_res  = (w_u >> 1) ^ {DATA_W{w_u[0]}};

  assign oValid     = (fcnt_q != '0);
  assign w_full     = (fcnt_q == C_FULL_CNT);
  assign w_pop      = oValid & iReady;
  assign w_push_req = (state_q == S_RUN) & iDecDone;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push     = w_push_req & (~w_full | w_pop);

  assign oDecEn     = (state_q == S_RUN) && (fcnt_q <= C_EN_LIMIT);
  assign oResidual  = oValid ? mem_q[rd_q] : '0;
  assign oPartIdx   = part_idx_q;
  assign oBusy      = (state_q != S_IDLE);
  assign oOverflow  = ovf_q;
  assign oBlockDone = (state_q == S_DRAIN) && (fcnt_q == '0);
  assign oPartDone  = ((state_q == S_PARAM) && iParamValid && (w_load_cnt == 16'd0)) ||
                      ((state_q == S_RUN) && iDecDone && (cnt_q == 16'd1));

  always_comb begin
    state_d    = state_q;
    part_len_d = part_len_q;
    pord_d     = pord_q;
    pred_d     = pred_q;
    part_idx_d = part_idx_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          pord_d     = iPartOrder;
          pred_d     = iPredOrder;
          part_len_d = iBlockSize >> iPartOrder;
          part_idx_d = 16'd0;
          state_d    = S_PARAM;
        end
      end
      S_PARAM: begin
        if (iParamValid) begin
          k_d   = iRiceParam;
          cnt_d = w_load_cnt;
          if (w_load_cnt != 16'd0) begin
            state_d = S_RUN;
          end else if (w_is_last) begin
            state_d = S_DRAIN;
          end else begin
            part_idx_d = part_idx_q + 16'd1;
          end
        end
      end
      S_RUN: begin
        if (iDecDone) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            if (w_is_last) begin
              state_d = S_DRAIN;
            end else begin
              part_idx_d = part_idx_q + 16'd1;
              state_d    = S_PARAM;
            end
          end
        end
      end
      default: begin
        if (fcnt_q == '0) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q    <= S_IDLE;
      part_len_q <= 16'd0;
      pord_q     <= 4'd0;
      pred_q     <= 6'd0;
      part_idx_q <= 16'd0;
      k_q        <= 4'd0;
      cnt_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      part_len_q <= part_len_d;
      pord_q     <= pord_d;
      pred_q     <= pred_d;
      part_idx_q <= part_idx_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (w_push) wr_q <= wr_q + AW'(1);
      if (w_pop)  rd_q <= rd_q + AW'(1);
      if (w_push && !w_pop)      fcnt_q <= fcnt_q + (AW+1)'(1);
      else if (!w_push && w_pop) fcnt_q <= fcnt_q - (AW+1)'(1);
      if (w_push_req && w_full && !w_pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (w_push) mem_q[wr_q] <= w_res;
  end

endmodule

`default_nettype wire
